// File: rtl/text_fetch.sv
// Text-mode fetch stage: pixel position -> character cell -> VRAM character code,
// with sync/blink-cursor sideband aligned to the 2-clock read pipeline and a clear-screen sweep.
module text_fetch #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 60,
    parameter int          ADDR_W       = 13,
    parameter logic [7:0]  FILL_CHR     = 8'h20,
    parameter int          BLINK_FRAMES = 30,
    parameter int          SYNC_DLY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic              de_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic              clr_i,
    input  logic              cursor_en_i,
    input  logic [ADDR_W-1:0] cursor_addr_i,
    output logic [7:0]        chr_ord_o,
    output logic [2:0]        cell_col_o,
    output logic [2:0]        cell_lin_o,
    output logic              cursor_o,
    output logic              busy_o,
    output logic              hs_o,
    output logic              vs_o,
    output logic              de_o
);

    localparam int                DEPTH      = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W + 1)'(DEPTH);
    localparam logic [10:0]       COLS_V     = 11'(COLS);
    localparam logic [7:0]        BLINK_LAST = 8'(BLINK_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // row*COLS built from the set bits of COLS as a sum of shifted rows (no multiplier).
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] row, input logic [6:0] col);
        logic [19:0] acc;
        acc = 20'd0;
        for (int b = 0; b < 11; b++) begin
            if (COLS_V[b]) begin
                acc = acc + (20'(row) << b);
            end else begin
                acc = acc;
            end
        end
        acc = acc + 20'(col);
        return acc[ADDR_W-1:0];
    endfunction

    logic [7:0]              r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0]       w_addr;
    logic                    w_match;
    logic [ADDR_W-1:0]       r_addr;
    logic [2:0]              r_xc0, r_yc0, r_xc1, r_yc1;
    logic                    r_de0, r_de1, r_match0, r_match1;
    logic [7:0]              r_q;
    state_t                  r_state, w_state_nxt;
    logic [ADDR_W-1:0]       r_clr_addr, w_clr_addr_nxt;
    logic                    w_clr_we, w_host_ok;
    logic                    r_busy;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_wa;
    logic [7:0]              w_wd;
    logic                    r_vs_d, r_phase;
    logic [7:0]              r_blink_cnt;
    logic [SYNC_DLY-1:0][2:0] r_sync;

    // Cell address and cursor compare for the current pixel.
    always_comb begin
        w_addr  = cell_addr(y_i[9:3], x_i[9:3]);
        w_match = (w_addr == cursor_addr_i);
    end

    // Pipeline stage c0: address and sideband capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr   <= '0;
            r_xc0    <= 3'd0;
            r_yc0    <= 3'd0;
            r_de0    <= 1'b0;
            r_match0 <= 1'b0;
        end else begin
            r_addr   <= w_addr;
            r_xc0    <= x_i[2:0];
            r_yc0    <= y_i[2:0];
            r_de0    <= de_i;
            r_match0 <= w_match;
        end
    end

    // Pipeline stage c1: sideband travels alongside the VRAM read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_xc1    <= 3'd0;
            r_yc1    <= 3'd0;
            r_de1    <= 1'b0;
            r_match1 <= 1'b0;
        end else begin
            r_xc1    <= r_xc0;
            r_yc1    <= r_yc0;
            r_de1    <= r_de0;
            r_match1 <= r_match0;
        end
    end

    // VRAM: read-first, so a same-cycle write to the read address returns old data.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_wa] <= w_wd;
        end
        r_q <= r_mem[r_addr];
    end

    // Clear FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_busy     <= (w_state_nxt == ST_CLEAR);
        end
    end

    // Clear FSM next state; clr_i is only honoured from IDLE.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_i) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == LAST_A) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    // Write-port arbitration: the sweep owns the port; host writes need range and idle.
    always_comb begin
        w_host_ok = wr_en_i & ~r_busy & ({1'b0, wr_addr_i} < DEPTH_X);
        w_we      = 1'b0;
        w_wa      = '0;
        w_wd      = 8'h00;
        if (w_clr_we) begin
            w_we = ~rst_i;
            w_wa = r_clr_addr;
            w_wd = FILL_CHR;
        end else if (w_host_ok) begin
            w_we = ~rst_i;
            w_wa = wr_addr_i;
            w_wd = wr_data_i;
        end else begin
            w_we = 1'b0;
        end
    end

    // Frame counter on vs rising edges; phase toggles each BLINK_FRAMES frames.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vs_d      <= 1'b0;
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b0;
        end else begin
            r_vs_d <= vs_i;
            if (vs_i & ~r_vs_d) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= 8'd0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    // Sync delay line, bit 2 = hs, 1 = vs, 0 = de.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DLY-2:0], {hs_i, vs_i, de_i}};
        end
    end

    assign chr_ord_o  = r_de1 ? r_q : 8'h00;
    assign cell_col_o = r_xc1;
    assign cell_lin_o = r_yc1;
    assign cursor_o   = r_de1 & r_match1 & cursor_en_i & r_phase;
    assign busy_o     = r_busy;
    assign hs_o       = r_sync[SYNC_DLY-1][2];
    assign vs_o       = r_sync[SYNC_DLY-1][1];
    assign de_o       = r_sync[SYNC_DLY-1][0];

endmodule

// File: doc/text_fetch.md
Name: text_fetch

Overview:
Text-mode fetch stage that sits between the VGA timing generator and the 8x8 glyph generator. It converts the pixel position into a character-cell address and reads the character code from an internal VRAM. It then presents the code, cell column and cell line to the glyph stage, with sync and blink-cursor sideband aligned to that data. A host write port and a hardware clear-screen sweep maintain the VRAM contents.

Parameters:
COLS, 80, characters per text row
ROWS, 60, text rows per frame
ADDR_W, 13, VRAM address width; must satisfy 2^ADDR_W >= COLS*ROWS
FILL_CHR, 8'h20, character code written by the clear sweep
BLINK_FRAMES, 30, frames per cursor blink half-period (1..255)
SYNC_DLY, 2, clock delay applied to hs/vs/de (minimum 2)

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous reset, active-high
x_i  in  10  pixel column from timing generator
y_i  in  10  pixel line from timing generator
de_i  in  1  active video
hs_i  in  1  horizontal sync
vs_i  in  1  vertical sync (active-high)
wr_en_i  in  1  host VRAM write strobe
wr_addr_i  in  ADDR_W  host write address (row*COLS+col)
wr_data_i  in  8  host character code
clr_i  in  1  start clear-screen sweep (pulse)
cursor_en_i  in  1  cursor enable
cursor_addr_i  in  ADDR_W  cursor cell address
chr_ord_o  out  8  character code to glyph stage
cell_col_o  out  3  x[2:0] aligned with chr_ord_o
cell_lin_o  out  3  y[2:0] aligned with chr_ord_o
cursor_o  out  1  current cell is the visible cursor
busy_o  out  1  clear sweep in progress
hs_o, vs_o, de_o  out  1 each  sync and active video delayed by SYNC_DLY

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, blink counter 0, blink phase 0. VRAM contents are not reset.
- Read pipeline, latency 2 clocks from x_i/y_i/de_i to chr_ord_o/cell_col_o/cell_lin_o/cursor_o:
  - c0: register addr = (y_i>>3)*COLS + (x_i>>3). The multiply uses shifts/adds only. Also register x[2:0], y[2:0], de_i, and the cursor match (addr==cursor_addr_i).
  - c1: synchronous VRAM read; register the sideband again.
  - Output: chr_ord_o = vram_q when the delayed de is 1, else 8'h00. cell_col_o and cell_lin_o are the delayed x[2:0] and y[2:0].
- cursor_o = delayed de & delayed match & cursor_en_i & blink phase.
- hs_o, vs_o, de_o: shift register of length SYNC_DLY.
- VRAM: COLS*ROWS x 8, true read port plus a write port. The write port is shared by host writes and the clear FSM.
  - A host write lands in the cycle after wr_en_i.
  - A read of the same address in the same cycle returns the old data.
- Host write rules:
  - wr_addr_i >= COLS*ROWS: write dropped.
  - wr_en_i while busy_o=1: write dropped.
- Clear FSM:
  - IDLE -> CLEAR on clr_i=1. busy_o rises on the next clock.
  - CLEAR writes FILL_CHR to addresses 0..COLS*ROWS-1, one per clock. It returns to IDLE after the last address, and busy_o falls on the clock after that final write (busy high for exactly COLS*ROWS clocks).
  - clr_i during CLEAR is ignored (no restart).
  - rst_i during CLEAR aborts to IDLE. Cells already cleared stay cleared.
- Blink:
  - A frame counter increments on each vs_i rising edge (detected with a 1-clock registered copy).
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- Coordinates with de_i=0 are never decoded: the address is don't-care, chr_ord_o=0 and cursor_o=0.

Test Plan:
- Reset then write 8'h41 to addr 0 and 8'h42 to addr 81. Drive x=0,y=0 then x=8,y=8 with de=1 -> chr_ord_o=8'h41 two clocks after x=0, then 8'h42 two clocks after (8,8); cell_col_o/cell_lin_o track x[2:0]/y[2:0] with the same 2-clock lag.
- Pulse clr_i -> busy_o high for exactly 4800 clocks. Afterwards every cell reads 8'h20. A wr_en_i to addr 5 issued mid-sweep leaves addr 5 at 8'h20.
- Write with wr_addr_i=4800 -> no VRAM change. Write to addr 4799, scan x=632,y=472 -> reads the written value.
- cursor_en_i=1, cursor_addr_i=2, pulse vs_i 30 times -> blink phase becomes 1 after the 30th rising edge and cursor_o=1 only during x=16..23 of lines 0..7 (2-clock lag). After 30 more edges the phase returns to 0 and cursor_o=0.
- de_i=0 with VRAM all 8'hFF -> chr_ord_o=0 and cursor_o=0. hs_o/vs_o/de_o equal the inputs delayed by SYNC_DLY clocks.
- Assert rst_i 100 clocks into a sweep -> busy_o=0 the next clock, FSM idle. Cells 0..~98 read FILL_CHR and higher cells are unchanged.
